// File: rtl/inv_sub_bytes.sv
// AES inverse SubBytes: each byte lane of the input word is replaced by its inverse S-box value.
// Latency 1 cycle registered (out/out_valid); zero-latency combinational with INV_SUB_BYTES_COMB_EN.
// No backpressure: a word is accepted on every cycle in_valid is high.
module inv_sub_bytes #(
    parameter int SIZE = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [SIZE-1:0] in,
    output logic            out_valid,
    output logic [SIZE-1:0] out
);

    localparam int LANES = SIZE / 8;

    generate
        if (SIZE <= 0 || (SIZE % 8) != 0) begin : g_bad_size
            $error("inv_sub_bytes: SIZE must be a positive multiple of 8");
        end
    endgenerate

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        case (b)
            8'h00: r = 8'h52;  8'h01: r = 8'h09;  8'h02: r = 8'h6a;  8'h03: r = 8'hd5;
            8'h04: r = 8'h30;  8'h05: r = 8'h36;  8'h06: r = 8'ha5;  8'h07: r = 8'h38;
            8'h08: r = 8'hbf;  8'h09: r = 8'h40;  8'h0a: r = 8'ha3;  8'h0b: r = 8'h9e;
            8'h0c: r = 8'h81;  8'h0d: r = 8'hf3;  8'h0e: r = 8'hd7;  8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c;  8'h11: r = 8'he3;  8'h12: r = 8'h39;  8'h13: r = 8'h82;
            8'h14: r = 8'h9b;  8'h15: r = 8'h2f;  8'h16: r = 8'hff;  8'h17: r = 8'h87;
            8'h18: r = 8'h34;  8'h19: r = 8'h8e;  8'h1a: r = 8'h43;  8'h1b: r = 8'h44;
            8'h1c: r = 8'hc4;  8'h1d: r = 8'hde;  8'h1e: r = 8'he9;  8'h1f: r = 8'hcb;
            8'h20: r = 8'h54;  8'h21: r = 8'h7b;  8'h22: r = 8'h94;  8'h23: r = 8'h32;
            8'h24: r = 8'ha6;  8'h25: r = 8'hc2;  8'h26: r = 8'h23;  8'h27: r = 8'h3d;
            8'h28: r = 8'hee;  8'h29: r = 8'h4c;  8'h2a: r = 8'h95;  8'h2b: r = 8'h0b;
            8'h2c: r = 8'h42;  8'h2d: r = 8'hfa;  8'h2e: r = 8'hc3;  8'h2f: r = 8'h4e;
            8'h30: r = 8'h08;  8'h31: r = 8'h2e;  8'h32: r = 8'ha1;  8'h33: r = 8'h66;
            8'h34: r = 8'h28;  8'h35: r = 8'hd9;  8'h36: r = 8'h24;  8'h37: r = 8'hb2;
            8'h38: r = 8'h76;  8'h39: r = 8'h5b;  8'h3a: r = 8'ha2;  8'h3b: r = 8'h49;
            8'h3c: r = 8'h6d;  8'h3d: r = 8'h8b;  8'h3e: r = 8'hd1;  8'h3f: r = 8'h25;
            8'h40: r = 8'h72;  8'h41: r = 8'hf8;  8'h42: r = 8'hf6;  8'h43: r = 8'h64;
            8'h44: r = 8'h86;  8'h45: r = 8'h68;  8'h46: r = 8'h98;  8'h47: r = 8'h16;
            8'h48: r = 8'hd4;  8'h49: r = 8'ha4;  8'h4a: r = 8'h5c;  8'h4b: r = 8'hcc;
            8'h4c: r = 8'h5d;  8'h4d: r = 8'h65;  8'h4e: r = 8'hb6;  8'h4f: r = 8'h92;
            8'h50: r = 8'h6c;  8'h51: r = 8'h70;  8'h52: r = 8'h48;  8'h53: r = 8'h50;
            8'h54: r = 8'hfd;  8'h55: r = 8'hed;  8'h56: r = 8'hb9;  8'h57: r = 8'hda;
            8'h58: r = 8'h5e;  8'h59: r = 8'h15;  8'h5a: r = 8'h46;  8'h5b: r = 8'h57;
            8'h5c: r = 8'ha7;  8'h5d: r = 8'h8d;  8'h5e: r = 8'h9d;  8'h5f: r = 8'h84;
            8'h60: r = 8'h90;  8'h61: r = 8'hd8;  8'h62: r = 8'hab;  8'h63: r = 8'h00;
            8'h64: r = 8'h8c;  8'h65: r = 8'hbc;  8'h66: r = 8'hd3;  8'h67: r = 8'h0a;
            8'h68: r = 8'hf7;  8'h69: r = 8'he4;  8'h6a: r = 8'h58;  8'h6b: r = 8'h05;
            8'h6c: r = 8'hb8;  8'h6d: r = 8'hb3;  8'h6e: r = 8'h45;  8'h6f: r = 8'h06;
            8'h70: r = 8'hd0;  8'h71: r = 8'h2c;  8'h72: r = 8'h1e;  8'h73: r = 8'h8f;
            8'h74: r = 8'hca;  8'h75: r = 8'h3f;  8'h76: r = 8'h0f;  8'h77: r = 8'h02;
            8'h78: r = 8'hc1;  8'h79: r = 8'haf;  8'h7a: r = 8'hbd;  8'h7b: r = 8'h03;
            8'h7c: r = 8'h01;  8'h7d: r = 8'h13;  8'h7e: r = 8'h8a;  8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a;  8'h81: r = 8'h91;  8'h82: r = 8'h11;  8'h83: r = 8'h41;
            8'h84: r = 8'h4f;  8'h85: r = 8'h67;  8'h86: r = 8'hdc;  8'h87: r = 8'hea;
            8'h88: r = 8'h97;  8'h89: r = 8'hf2;  8'h8a: r = 8'hcf;  8'h8b: r = 8'hce;
            8'h8c: r = 8'hf0;  8'h8d: r = 8'hb4;  8'h8e: r = 8'he6;  8'h8f: r = 8'h73;
            8'h90: r = 8'h96;  8'h91: r = 8'hac;  8'h92: r = 8'h74;  8'h93: r = 8'h22;
            8'h94: r = 8'he7;  8'h95: r = 8'had;  8'h96: r = 8'h35;  8'h97: r = 8'h85;
            8'h98: r = 8'he2;  8'h99: r = 8'hf9;  8'h9a: r = 8'h37;  8'h9b: r = 8'he8;
            8'h9c: r = 8'h1c;  8'h9d: r = 8'h75;  8'h9e: r = 8'hdf;  8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47;  8'ha1: r = 8'hf1;  8'ha2: r = 8'h1a;  8'ha3: r = 8'h71;
            8'ha4: r = 8'h1d;  8'ha5: r = 8'h29;  8'ha6: r = 8'hc5;  8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f;  8'ha9: r = 8'hb7;  8'haa: r = 8'h62;  8'hab: r = 8'h0e;
            8'hac: r = 8'haa;  8'had: r = 8'h18;  8'hae: r = 8'hbe;  8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc;  8'hb1: r = 8'h56;  8'hb2: r = 8'h3e;  8'hb3: r = 8'h4b;
            8'hb4: r = 8'hc6;  8'hb5: r = 8'hd2;  8'hb6: r = 8'h79;  8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a;  8'hb9: r = 8'hdb;  8'hba: r = 8'hc0;  8'hbb: r = 8'hfe;
            8'hbc: r = 8'h78;  8'hbd: r = 8'hcd;  8'hbe: r = 8'h5a;  8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f;  8'hc1: r = 8'hdd;  8'hc2: r = 8'ha8;  8'hc3: r = 8'h33;
            8'hc4: r = 8'h88;  8'hc5: r = 8'h07;  8'hc6: r = 8'hc7;  8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1;  8'hc9: r = 8'h12;  8'hca: r = 8'h10;  8'hcb: r = 8'h59;
            8'hcc: r = 8'h27;  8'hcd: r = 8'h80;  8'hce: r = 8'hec;  8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60;  8'hd1: r = 8'h51;  8'hd2: r = 8'h7f;  8'hd3: r = 8'ha9;
            8'hd4: r = 8'h19;  8'hd5: r = 8'hb5;  8'hd6: r = 8'h4a;  8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d;  8'hd9: r = 8'he5;  8'hda: r = 8'h7a;  8'hdb: r = 8'h9f;
            8'hdc: r = 8'h93;  8'hdd: r = 8'hc9;  8'hde: r = 8'h9c;  8'hdf: r = 8'hef;
            8'he0: r = 8'ha0;  8'he1: r = 8'he0;  8'he2: r = 8'h3b;  8'he3: r = 8'h4d;
            8'he4: r = 8'hae;  8'he5: r = 8'h2a;  8'he6: r = 8'hf5;  8'he7: r = 8'hb0;
            8'he8: r = 8'hc8;  8'he9: r = 8'heb;  8'hea: r = 8'hbb;  8'heb: r = 8'h3c;
            8'hec: r = 8'h83;  8'hed: r = 8'h53;  8'hee: r = 8'h99;  8'hef: r = 8'h61;
            8'hf0: r = 8'h17;  8'hf1: r = 8'h2b;  8'hf2: r = 8'h04;  8'hf3: r = 8'h7e;
            8'hf4: r = 8'hba;  8'hf5: r = 8'h77;  8'hf6: r = 8'hd6;  8'hf7: r = 8'h26;
            8'hf8: r = 8'he1;  8'hf9: r = 8'h69;  8'hfa: r = 8'h14;  8'hfb: r = 8'h63;
            8'hfc: r = 8'h55;  8'hfd: r = 8'h21;  8'hfe: r = 8'h0c;  8'hff: r = 8'h7d;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Lanes are independent table lookups; no byte ever crosses a lane.
    logic [SIZE-1:0] sub_dat;

    always_comb begin
        sub_dat = '0;
        for (int i = 0; i < LANES; i++) begin
            sub_dat[8*i +: 8] = inv_sbox(in[8*i +: 8]);
        end
    end

`ifdef INV_SUB_BYTES_COMB_EN
    // Clock and reset have no role in the zero-latency build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign out       = sub_dat;
    assign out_valid = in_valid;
`else
    logic [SIZE-1:0] out_q;
    logic [SIZE-1:0] out_d;
    logic            out_vld_q;
    logic            out_vld_d;

    // Data holds when idle; only the valid strobe drops.
    always_comb begin
        out_d     = out_q;
        out_vld_d = in_valid;
        if (in_valid) begin
            out_d = sub_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_vld_q;
`endif

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Bench for inv_sub_bytes at SIZE=128 and SIZE=256; reference inverse S-box is derived
// from GF(2^8) inversion and the forward affine map, then checked every cycle.
module tb_inv_sub_bytes;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         vld = 1'b0;
    logic [127:0] in128 = '0;
    logic [255:0] in256 = '0;
    logic         ovld128;
    logic [127:0] out128;
    logic         ovld256;
    logic [255:0] out256;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   inv_tab [256];
    logic [127:0] exp128 = '0;
    logic [255:0] exp256 = '0;
    logic         exp_vld = 1'b0;

    inv_sub_bytes #(.SIZE(128)) u_d128 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .in(in128),
        .out_valid(ovld128), .out(out128)
    );

    inv_sub_bytes #(.SIZE(256)) u_d256 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld), .in(in256),
        .out_valid(ovld256), .out(out256)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box = affine(GF inverse); the inverse table is its permutation inverse.
    task automatic build_table();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [255:0] map_bytes(input logic [255:0] x, input int nbytes);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < nbytes; i++) r[8*i +: 8] = inv_tab[x[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a word accepted on a live edge appears next cycle; reset clears at once.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp128  <= '0;
            exp256  <= '0;
            exp_vld <= 1'b0;
        end else begin
            exp_vld <= vld;
            if (vld) begin
                exp128 <= map_bytes({128'h0, in128}, 16)[127:0];
                exp256 <= map_bytes(in256, 32);
            end
        end
    end

    always @(negedge clk) begin
        chk("vld128", {255'h0, ovld128}, {255'h0, exp_vld});
        chk("out128", {128'h0, out128}, {128'h0, exp128});
        chk("vld256", {255'h0, ovld256}, {255'h0, exp_vld});
        chk("out256", out256, exp256);
    end

    task automatic drive(input logic v, input logic [127:0] d128, input logic [255:0] d256);
        @(posedge clk);
        #2;
        vld   = v;
        in128 = d128;
        in256 = d256;
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hD4E0B81E27BFB44111985D52AEF1E530;
    localparam logic [127:0] FIPS_OUT = 128'h19A09AE93DF4C6F8E3E28D48BE2B2A08;
    localparam logic [127:0] LOW_IN   = 128'h49457F77DEDB3902D296875389F11A3B;

    initial begin
        logic [127:0] ones63;
        logic [127:0] r128;
        logic [255:0] r256;
        build_table();
        chk("tab00", {248'h0, inv_tab[8'h00]}, 256'h52);
        chk("tab01", {248'h0, inv_tab[8'h01]}, 256'h09);
        chk("tab53", {248'h0, inv_tab[8'h53]}, 256'h50);
        chk("tab63", {248'h0, inv_tab[8'h63]}, 256'h00);
        chk("tab7C", {248'h0, inv_tab[8'h7C]}, 256'h01);
        chk("tabFF", {248'h0, inv_tab[8'hFF]}, 256'h7D);
        ones63 = {16{8'h63}};

        // Reset held with valid input present.
        vld = 1'b1; in128 = '1; in256 = '1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out128", {128'h0, out128}, 256'h0);
        chk("rst_vld256", {255'h0, ovld256}, 256'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst128", {128'h0, out128}, {128'h0, {16{8'h7D}}});
        chk("post_rst256", out256, {32{8'h7D}});
        chk("post_rst_vld", {255'h0, ovld128}, 256'h1);

        // FIPS round-state example.
        drive(1'b1, FIPS_IN, {FIPS_IN, LOW_IN});
        drive(1'b0, '0, '0);
        @(negedge clk);
        chk("fips128", {128'h0, out128}, {128'h0, FIPS_OUT});
        chk("fips256_hi", {128'h0, out256[255:128]}, {128'h0, FIPS_OUT});

        // Every byte value through lane 0, back to back.
        for (int b = 0; b < 256; b++) begin
            drive(1'b1, {ones63[127:8], 8'(b)}, {ones63, ones63[127:8], 8'(b)});
        end

        // Hold: data frozen once valid drops.
        drive(1'b1, ones63, {ones63, ones63});
        drive(1'b0, '1, '1);
        @(negedge clk);
        chk("hold_out_a", {128'h0, out128}, 256'h0);
        @(posedge clk);
        @(negedge clk);
        chk("hold_out_b", out256, 256'h0);
        chk("hold_vld", {255'h0, ovld128}, 256'h0);

        // Reset between edges while a result is valid; the word at the inputs is dropped.
        drive(1'b1, FIPS_IN, {FIPS_IN, FIPS_IN});
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_vld", {255'h0, ovld128}, 256'h1);
        #1;
        rst_n = 1'b0;
        in128 = ones63; in256 = {ones63, ones63};
        #1;
        chk("mid_rst128", {128'h0, out128}, 256'h0);
        chk("mid_rst256", out256, 256'h0);
        chk("mid_rst_vld", {254'h0, ovld128, ovld256}, 256'h0);
        @(posedge clk);
        #2;
        vld = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("after_rst128", {128'h0, out128}, 256'h0);

        // Randomized traffic.
        repeat (400) begin
            r128 = {$urandom, $urandom, $urandom, $urandom};
            r256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 3) != 0), r128, r256);
        end
        drive(1'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes.md
Name:
inv_sub_bytes

Overview:
- AES inverse SubBytes stage for the decryption datapath: every byte of the input word is replaced by its FIPS-197 inverse S-box value.
- Width is parameterised, so one block serves a 128-bit state or wider packed words (e.g. 256 bits).
- Output is registered, one clock of latency, qualified by a valid strobe; sits between InvShiftRows and AddRoundKey in the round pipeline.

Parameters:
- SIZE, 128, data width in bits; must be a positive multiple of 8 (elaboration error otherwise); SIZE/8 independent byte lanes.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in carries a word to transform this cycle
- in  input  SIZE  packed input bytes; lane i = in[8i+7:8i]
- out_valid  output  1  out holds a freshly transformed word
- out  output  SIZE  packed result bytes; lane i = out[8i+7:8i]

Behaviour:
- Lane function: out lane i = InvSbox(in lane i), FIPS-197 inverse S-box (256-entry constant table). Lanes are fully independent; no inter-byte mixing or reordering.
- Reset: rst_n low asynchronously forces out = 0 and out_valid = 0, held while rst_n is low. Reset mid-operation discards any word in flight; first capture is on the first rising clk edge with rst_n high.
- Latency: exactly 1 cycle. On rising clk with in_valid=1: out <= InvSbox(in) per lane, out_valid <= 1.
- in_valid=0 at an edge: out holds its previous value, out_valid <= 0.
- Back-to-back: in_valid high every cycle gives one result per cycle, no bubbles; no backpressure (no ready signal).
- Table boundaries: InvSbox(00)=52, (01)=09, (53)=50, (63)=00, (7C)=01, (FF)=7D.
- No X propagation beyond lanes whose in bits are X; table is a pure function.

Optional Feature:
- Macro INV_SUB_BYTES_COMB_EN.
- Defined: output register removed; out = InvSbox(in) per lane combinationally, out_valid = in_valid, zero latency; clk and rst_n are ignored.
- Not defined: registered 1-cycle behaviour described above (default build).

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and in=all FF across several edges -> out=0, out_valid=0 throughout; deassert -> next edge gives out lanes all 7D, out_valid=1.
- FIPS example, SIZE=128: in=D4E0B81E27BFB44111985D52AEF1E530, in_valid=1 -> one cycle later out=19A09AE93DF4C6F8E3E28D48BE2B2A08, out_valid=1.
- SIZE=256: in=D4E0B81E27BFB44111985D52AEF1E53049457F77DEDB3902D296875389F11A3B -> upper 128 bits of out = 19A09AE93DF4C6F8E3E28D48BE2B2A08; every lower-half lane equals the table value of its input byte; out_valid=1 after 1 cycle.
- Exhaustive table: stream bytes 00..FF in lane 0 (other lanes 63) back-to-back -> each cycle lane 0 matches InvSbox reference (00->52, 01->09, 53->50, FF->7D), other lanes 00, out_valid continuously 1.
- Hold/valid: in_valid=1 with 63636363... then in_valid=0 with in changed to FF... -> out stays 00...00, out_valid drops to 0 on the second edge.
- Reset mid-stream: assert rst_n low between edges while out_valid=1 -> out and out_valid go 0 immediately (before next edge); in-flight word is never output.
